// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_TURN
    } arb_state_t;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int MAX_MASTERS = 32;
    localparam int TIMEOUT_W   = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant/frame signals between bus masters and the arbiter
interface bus_arbiter_if #(
    parameter int N_MASTERS = 8,
    parameter int IDW       = $clog2(N_MASTERS)
);
    logic [N_MASTERS-1:0] req_b;
    logic                 frame_b;
    logic                 irdy_b;
    logic [N_MASTERS-1:0] gnt_b;
    logic [IDW-1:0]       owner;
    logic                 bus_busy;
    logic                 timeout_err;
    logic [IDW-1:0]       timeout_id;

    modport master (
        output req_b, frame_b, irdy_b,
        input  gnt_b, owner, bus_busy, timeout_err, timeout_id
    );

    modport slave (
        input  req_b, frame_b, irdy_b,
        output gnt_b, owner, bus_busy, timeout_err, timeout_id
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational rotate-and-priority-encode from a start index
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 8,
    parameter int IDW       = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDW-1:0]       start,
    output logic [IDW-1:0]       winner,
    output logic                 valid
);
    int             idx;
    logic [IDW-1:0] idx_w;

    // Walk upward from start with wrap; the first active request wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (i < N_MASTERS) begin
                idx   = (int'(start) + i) % N_MASTERS;
                idx_w = IDW'(idx);
                if (!valid && req[idx_w]) begin
                    winner = idx_w;
                    valid  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - central REQ_B/GNT_B arbiter with ownership tracking and grant timeout
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS   = 8,
    parameter int ARB_MODE    = ARB_RR,
    parameter int GNT_TIMEOUT = 16,
    parameter int IDW         = $clog2(N_MASTERS)
) (
    input  logic clk,
    input  logic rstb,
    bus_arbiter_if.slave bus
);
    arb_state_t             state;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         start_ptr;
    logic [IDW-1:0]         winner;
    logic                   win_valid;
    logic [TIMEOUT_W-1:0]   cnt;
    logic [TIMEOUT_W-1:0]   cnt_next;
    logic [N_MASTERS-1:0]   req_act;

    assign req_act   = ~bus.req_b;
    assign cnt_next  = cnt + TIMEOUT_W'(1);
    assign start_ptr = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;

    rr_picker #(
        .N_MASTERS (N_MASTERS),
        .IDW       (IDW)
    ) u_picker (
        .req    (req_act),
        .start  (start_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state           <= ST_IDLE;
            bus.gnt_b       <= '1;
            bus.owner       <= '0;
            bus.bus_busy    <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.timeout_id  <= '0;
            rr_ptr          <= '0;
            cnt             <= '0;
        end else begin
            bus.timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state             <= ST_GRANT;
                        bus.gnt_b         <= '1;
                        bus.gnt_b[winner] <= 1'b0;
                        bus.owner         <= winner;
                        bus.bus_busy      <= 1'b1;
                        cnt               <= '0;
                        if (ARB_MODE == ARB_RR) begin
                            rr_ptr <= (winner == IDW'(N_MASTERS - 1)) ? '0 : winner + IDW'(1);
                        end
                    end
                end
                // Precedence: FRAME_B start, then withdrawal, then timeout.
                ST_GRANT: begin
                    if (!bus.frame_b) begin
                        state     <= ST_BUSY;
                        bus.gnt_b <= '1;
                    end else if (bus.req_b[bus.owner]) begin
                        state        <= ST_IDLE;
                        bus.gnt_b    <= '1;
                        bus.bus_busy <= 1'b0;
                    end else if (cnt_next == TIMEOUT_W'(GNT_TIMEOUT)) begin
                        state           <= ST_IDLE;
                        bus.gnt_b       <= '1;
                        bus.bus_busy    <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        bus.timeout_id  <= bus.owner;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_BUSY: begin
                    if (bus.frame_b && bus.irdy_b) begin
                        state        <= ST_TURN;
                        bus.bus_busy <= 1'b0;
                    end
                end
                ST_TURN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized scoreboard bench for fixed-priority and round-robin arbiters
module tb_bus_arbiter;
    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    int         cyc  = 0;
    int         tests = 0;
    int         fails = 0;
    int         mptr  = 0;
    int         expq0[$];
    int         expq1[$];
    int         toq0[$];
    int         toq1[$];

    logic [7:0] req_v    [2];
    logic       frame_v  [2];
    logic       irdy_v   [2];
    logic [7:0] gnt_w    [2];
    logic [2:0] owner_w  [2];
    logic [2:0] tid_w    [2];
    logic       busy_w   [2];
    logic       terr_w   [2];
    logic [7:0] prev_gnt [2];

    bus_arbiter_if #(.N_MASTERS(8)) if_fx ();
    bus_arbiter_if #(.N_MASTERS(8)) if_rr ();

    assign if_fx.req_b   = req_v[0];
    assign if_fx.frame_b = frame_v[0];
    assign if_fx.irdy_b  = irdy_v[0];
    assign if_rr.req_b   = req_v[1];
    assign if_rr.frame_b = frame_v[1];
    assign if_rr.irdy_b  = irdy_v[1];
    assign gnt_w[0]   = if_fx.gnt_b;
    assign gnt_w[1]   = if_rr.gnt_b;
    assign owner_w[0] = if_fx.owner;
    assign owner_w[1] = if_rr.owner;
    assign tid_w[0]   = if_fx.timeout_id;
    assign tid_w[1]   = if_rr.timeout_id;
    assign busy_w[0]  = if_fx.bus_busy;
    assign busy_w[1]  = if_rr.bus_busy;
    assign terr_w[0]  = if_fx.timeout_err;
    assign terr_w[1]  = if_rr.timeout_err;

    bus_arbiter #(.N_MASTERS(8), .ARB_MODE(0), .GNT_TIMEOUT(16)) dut_fx (
        .clk  (clk),
        .rstb (rstb),
        .bus  (if_fx)
    );

    bus_arbiter #(.N_MASTERS(8), .ARB_MODE(1), .GNT_TIMEOUT(16)) dut_rr (
        .clk  (clk),
        .rstb (rstb),
        .bus  (if_rr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: lowest requester at or above the pointer, else lowest overall.
    function automatic int model_pick(input int d, input logic [7:0] act);
        int start;
        start = (d == 1) ? mptr : 0;
        for (int j = start; j < 8; j++) if (act[j[2:0]]) return j;
        for (int j = 0; j < 8; j++) if (act[j[2:0]]) return j;
        return -1;
    endfunction

    task automatic push_grant(input int d, input int w);
        if (d == 0) expq0.push_back(w);
        else begin
            expq1.push_back(w);
            mptr = (w + 1) % 8;
        end
    endtask

    task automatic wait_grant(input int d, output int edge_no);
        bit done;
        edge_no = -1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                @(negedge clk);
                if (gnt_w[d] != 8'hFF) begin
                    edge_no = cyc;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic run_seq(input int d, input logic [7:0] act, input int n, input bit drop,
                           input int flen, input bit irdy_lag, input bit already);
        logic [7:0] cur;
        int w, g, t_exp;
        bit stop;
        cur = act;
        stop = 1'b0;
        if (!already) @(negedge clk);
        req_v[d] = ~cur;
        t_exp = cyc + 1;
        for (int k = 0; k < n; k++) begin
            if (!stop) begin
                w = model_pick(d, cur);
                push_grant(d, w);
                wait_grant(d, g);
                check(g == t_exp, "grant_edge", g, t_exp);
                check(int'(owner_w[d]) == w, "owner", int'(owner_w[d]), w);
                check(busy_w[d] == 1'b1, "busy_in_grant", int'(busy_w[d]), 1);
                frame_v[d] = 1'b0;
                irdy_v[d]  = 1'b0;
                if (drop) cur[w[2:0]] = 1'b0;
                if (k == n - 1) cur = 8'h00;
                req_v[d] = ~cur;
                @(negedge clk);
                check(gnt_w[d] == 8'hFF, "gnt_release", int'(gnt_w[d]), 255);
                check(busy_w[d] == 1'b1, "busy_in_busy", int'(busy_w[d]), 1);
                repeat (flen - 1) @(negedge clk);
                frame_v[d] = 1'b1;
                if (irdy_lag) @(negedge clk);
                irdy_v[d] = 1'b1;
                t_exp = cyc + 3;
                if (cur == 8'h00) stop = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_timeout(input int master, input logic [7:0] next_act);
        int g, r, w;
        @(negedge clk);
        req_v[1] = ~(8'h01 << master);
        w = model_pick(1, 8'h01 << master);
        push_grant(1, w);
        toq1.push_back(master);
        wait_grant(1, g);
        r = -1;
        for (int i = 0; i < 40; i++) begin
            if (r < 0) begin
                @(negedge clk);
                if (gnt_w[1] == 8'hFF) r = cyc;
            end
        end
        check(r == g + 16, "timeout_edge", r, g + 16);
        check(terr_w[1] == 1'b1, "timeout_err_pulse", int'(terr_w[1]), 1);
        check(busy_w[1] == 1'b0, "busy_after_timeout", int'(busy_w[1]), 0);
        req_v[1] = 8'hFF;
        @(negedge clk);
        check(terr_w[1] == 1'b0, "timeout_err_single", int'(terr_w[1]), 0);
        run_seq(1, next_act, 1, 1'b1, 2, 1'b0, 1'b1);
        check(int'(tid_w[1]) == master, "timeout_id_hold", int'(tid_w[1]), master);
    endtask

    task automatic run_race(input int master, input bit withdraw);
        int g;
        @(negedge clk);
        req_v[0] = ~(8'h01 << master);
        push_grant(0, model_pick(0, 8'h01 << master));
        wait_grant(0, g);
        while (cyc < g + 15) @(negedge clk);
        if (withdraw) req_v[0] = 8'hFF;
        else begin
            frame_v[0] = 1'b0;
            irdy_v[0]  = 1'b0;
        end
        @(negedge clk);
        check(gnt_w[0] == 8'hFF, "race_gnt", int'(gnt_w[0]), 255);
        check(terr_w[0] == 1'b0, "race_no_err", int'(terr_w[0]), 0);
        check(busy_w[0] == !withdraw, "race_busy", int'(busy_w[0]), int'(!withdraw));
        req_v[0] = 8'hFF;
        @(negedge clk);
        frame_v[0] = 1'b1;
        irdy_v[0]  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        int idx, nz, e;
        bit have;
        logic [7:0] gv;
        for (int d = 0; d < 2; d++) begin
            gv = gnt_w[d];
            if (rstb && gv != 8'hFF && prev_gnt[d] == 8'hFF) begin
                idx = -1;
                nz  = 0;
                for (int b = 0; b < 8; b++) begin
                    if (gv[b[2:0]] == 1'b0) begin
                        idx = b;
                        nz++;
                    end
                end
                have = (d == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
                if (!have) check(1'b0, "unexpected_grant", idx, -1);
                else begin
                    e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
                    check(idx == e, "grant_id", idx, e);
                    check(nz == 1, "grant_one_cold", nz, 1);
                end
            end
            if (terr_w[d]) begin
                have = (d == 0) ? (toq0.size() > 0) : (toq1.size() > 0);
                if (!have) check(1'b0, "unexpected_timeout", int'(tid_w[d]), -1);
                else begin
                    e = (d == 0) ? toq0.pop_front() : toq1.pop_front();
                    check(int'(tid_w[d]) == e, "timeout_id", int'(tid_w[d]), e);
                end
            end
            prev_gnt[d] = gv;
        end
    end

    initial begin
        int g, t;
        for (int d = 0; d < 2; d++) begin
            req_v[d]    = 8'h00;
            frame_v[d]  = 1'b1;
            irdy_v[d]   = 1'b1;
            prev_gnt[d] = 8'hFF;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(gnt_w[d] == 8'hFF, "reset_gnt", int'(gnt_w[d]), 255);
            check(terr_w[d] == 1'b0, "reset_terr", int'(terr_w[d]), 0);
            check(busy_w[d] == 1'b0, "reset_busy", int'(busy_w[d]), 0);
            check(owner_w[d] == 3'd0, "reset_owner", int'(owner_w[d]), 0);
            check(tid_w[d] == 3'd0, "reset_tid", int'(tid_w[d]), 0);
        end

        @(negedge clk);
        rstb = 1'b1;
        req_v[0] = 8'hFF;
        run_seq(1, 8'hFF, 9, 1'b0, 2, 1'b0, 1'b1);

        run_seq(0, 8'b1010_0000, 2, 1'b1, 2, 1'b0, 1'b0);
        run_seq(0, 8'b1010_1000, 3, 1'b1, 2, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_seq(int'($urandom_range(0, 1)), 8'($urandom_range(1, 255)),
                    int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        run_timeout(2, 8'b0000_1110);
        run_race(4, 1'b0);
        run_race(1, 1'b1);

        @(negedge clk);
        req_v[1] = ~8'h10;
        t = cyc + 1;
        push_grant(1, model_pick(1, 8'h10));
        wait_grant(1, g);
        check(g == t, "pre_reset_grant_edge", g, t);
        frame_v[1] = 1'b0;
        irdy_v[1]  = 1'b0;
        req_v[1]   = 8'hFF;
        @(negedge clk);
        check(busy_w[1] == 1'b1, "pre_reset_busy", int'(busy_w[1]), 1);
        req_v[0] = ~8'h40;
        t = cyc + 1;
        push_grant(0, model_pick(0, 8'h40));
        wait_grant(0, g);
        check(g == t, "pre_reset_fx_edge", g, t);
        #2 rstb = 1'b0;
        #1;
        check(gnt_w[0] == 8'hFF, "async_reset_gnt_fx", int'(gnt_w[0]), 255);
        check(gnt_w[1] == 8'hFF, "async_reset_gnt_rr", int'(gnt_w[1]), 255);
        check(busy_w[1] == 1'b0, "async_reset_busy", int'(busy_w[1]), 0);
        repeat (2) @(negedge clk);
        check(terr_w[0] == 1'b0 && terr_w[1] == 1'b0, "reset_no_terr",
              int'(terr_w[0]) + int'(terr_w[1]), 0);
        frame_v[1] = 1'b1;
        irdy_v[1]  = 1'b1;
        req_v[0]   = 8'hFF;
        mptr       = 0;
        rstb       = 1'b1;
        run_seq(1, 8'hFF, 1, 1'b1, 1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check(expq0.size() == 0, "fx_grants_pending", expq0.size(), 0);
        check(expq1.size() == 0, "rr_grants_pending", expq1.size(), 0);
        check(toq1.size() == 0, "timeouts_pending", toq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
